// File: rtl/cu_bus_pkg.sv
// Shared types and widths for the central-unit port bus arbiter.
package cu_bus_pkg;

  localparam int unsigned PORT_W = 3;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StWait,
    StDone
  } bus_state_t;

  typedef struct packed {
    logic              write;
    logic [PORT_W-1:0] port;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Minimum counter width able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/port_bus_arbiter_if.sv
// Requester and peripheral-side signals of the shared port bus.
interface port_bus_arbiter_if;
  import cu_bus_pkg::*;

  logic              m0_req;
  logic              m1_req;
  logic              m0_write;
  logic              m1_write;
  logic [PORT_W-1:0] m0_port;
  logic [PORT_W-1:0] m1_port;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m0_done;
  logic              m1_done;
  logic              m0_err;
  logic              m1_err;
  logic [PORT_W-1:0] port_id;
  logic              port_read;
  logic              port_write;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              port_ready;
  logic              busy;
  logic              owner;

  // Arbiter view.
  modport slave (
    input  m0_req, m1_req, m0_write, m1_write, m0_port, m1_port, m0_wdata, m1_wdata,
    input  data_in, port_ready,
    output m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
    output port_id, port_read, port_write, data_out, busy, owner
  );

  // Requester / peripheral view.
  modport master (
    output m0_req, m1_req, m0_write, m1_write, m0_port, m1_port, m0_wdata, m1_wdata,
    output data_in, port_ready,
    input  m0_rdata, m1_rdata, m0_done, m1_done, m0_err, m1_err,
    input  port_id, port_read, port_write, data_out, busy, owner
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a registered priority pointer.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic rr_q, rr_d;

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = (&req_i) ? rr_q : req_i[1];
    rr_d        = rr_q;
    // Priority passes to the master that did not win.
    if (accept_i && gnt_valid_o) begin
      rr_d = ~gnt_idx_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/port_bus_arbiter.sv
// Shares the 3-bit-address / 4-bit-data port bus between two requesters with
// round-robin grant, strobe/ready handshake and a bounded wait.
module port_bus_arbiter
  import cu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input logic               clock,
  input logic               reset,
  port_bus_arbiter_if.slave bus
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);

  bus_state_t        state_q, state_d;
  bus_req_t          req_q, req_d;
  logic              owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [PORT_W-1:0] port_id_q, port_id_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              port_read_q, port_read_d;
  logic              port_write_q, port_write_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_done_q, m0_done_d;
  logic              m1_done_q, m1_done_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_err_q, m1_err_d;
  logic              busy_q, busy_d;

  logic gnt_valid, gnt_idx, accept, timeout_hit;

  assign accept      = (state_q == StIdle);
  // Ready in the last allowed cycle is checked first, so it beats the timeout.
  assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;

  rr_arbiter2 u_rr (
    .clk_i       (clock),
    .rst_ni      (reset),
    .req_i       ({bus.m1_req, bus.m0_req}),
    .accept_i    (accept),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d = gnt_idx;
          if (gnt_idx) begin
            req_d = '{write: bus.m1_write, port: bus.m1_port, wdata: bus.m1_wdata};
          end else begin
            req_d = '{write: bus.m0_write, port: bus.m0_port, wdata: bus.m0_wdata};
          end
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StStrobe;
        end
      end
      StStrobe, StWait: begin
        if (bus.port_ready) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = StWait;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that every output is a flop.
  always_comb begin
    port_id_d    = '0;
    data_out_d   = '0;
    port_read_d  = 1'b0;
    port_write_d = 1'b0;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    busy_d       = (state_d != StIdle);
    if (state_d == StStrobe || state_d == StWait) begin
      port_id_d  = req_d.port;
      data_out_d = req_d.write ? req_d.wdata : '0;
    end
    if (state_d == StStrobe) begin
      port_write_d = req_d.write;
      port_read_d  = ~req_d.write;
    end
    if (state_d == StDone) begin
      if (owner_d) begin
        m1_done_d = 1'b1;
        m1_err_d  = err_d;
        if (!req_d.write) m1_rdata_d = err_d ? '0 : bus.data_in;
      end else begin
        m0_done_d = 1'b1;
        m0_err_d  = err_d;
        if (!req_d.write) m0_rdata_d = err_d ? '0 : bus.data_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      port_id_q    <= '0;
      data_out_q   <= '0;
      port_read_q  <= 1'b0;
      port_write_q <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      port_id_q    <= port_id_d;
      data_out_q   <= data_out_d;
      port_read_q  <= port_read_d;
      port_write_q <= port_write_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.port_id    = port_id_q;
  assign bus.data_out   = data_out_q;
  assign bus.port_read  = port_read_q;
  assign bus.port_write = port_write_q;
  assign bus.m0_rdata   = m0_rdata_q;
  assign bus.m1_rdata   = m1_rdata_q;
  assign bus.m0_done    = m0_done_q;
  assign bus.m1_done    = m1_done_q;
  assign bus.m0_err     = m0_err_q;
  assign bus.m1_err     = m1_err_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_port_bus_arbiter.sv
// Scoreboard bench for port_bus_arbiter: directed transactions push expected
// strobes and completions; a negedge monitor pops and compares them.
module tb_port_bus_arbiter;
  import cu_bus_pkg::*;

  localparam int unsigned TO = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  port_bus_arbiter_if bus ();

  port_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] p;
    logic       wr;
    logic [3:0] d;
    int         cyc;
  } strobe_exp_t;

  typedef struct {
    int         m;
    logic       err;
    logic [3:0] rdata;
    int         cyc;
  } done_exp_t;

  strobe_exp_t sq[$];
  done_exp_t   dq[$];
  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endfunction

  // Monitor
  logic prev_strobe = 1'b0;
  always @(negedge clock) begin
    logic        s;
    strobe_exp_t se;
    done_exp_t   de;
    s = bus.port_read | bus.port_write;
    if (reset) begin
      if (s) begin
        chk("strobe_back_to_back", int'(prev_strobe), 0);
        chk("strobe_both", int'(bus.port_read & bus.port_write), 0);
        chk("strobe_expected", int'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          se = sq.pop_front();
          chk("strobe_cycle", cyc, se.cyc);
          chk("strobe_port_id", int'(bus.port_id), int'(se.p));
          chk("strobe_write", int'(bus.port_write), int'(se.wr));
          chk("strobe_data_out", int'(bus.data_out), int'(se.d));
        end
      end
      if (bus.m0_done | bus.m1_done) begin
        chk("done_both", int'(bus.m0_done & bus.m1_done), 0);
        chk("done_expected", int'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          de = dq.pop_front();
          chk("done_cycle", cyc, de.cyc);
          chk("done_master", bus.m1_done ? 1 : 0, de.m);
          chk("done_err", int'(bus.m1_done ? bus.m1_err : bus.m0_err), int'(de.err));
          chk("done_rdata", int'(bus.m1_done ? bus.m1_rdata : bus.m0_rdata), int'(de.rdata));
        end
      end
      if (!bus.busy) begin
        chk("idle_port_id", int'(bus.port_id), 0);
        chk("idle_data_out", int'(bus.data_out), 0);
      end
      prev_strobe = s;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic drive(input int m, input logic v, input logic wr, input logic [2:0] p,
                       input logic [3:0] wd);
    if (m == 0) begin
      bus.m0_req = v; bus.m0_write = wr; bus.m0_port = p; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = v; bus.m1_write = wr; bus.m1_port = p; bus.m1_wdata = wd;
    end
  endtask

  task automatic wait_done(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if ((m == 0 && bus.m0_done) || (m == 1 && bus.m1_done)) ok = 1'b1;
    end
  endtask

  // One transaction from idle; k = cycles after the strobe until ready (-1 = never).
  task automatic run_txn(input int m, input logic wr, input logic [2:0] p, input logic [3:0] wd,
                         input int k, input logic [3:0] din, input logic exp_err,
                         input logic [3:0] exp_rd);
    int c0;
    bit ok;
    @(posedge clock); #1;
    c0 = cyc;
    sq.push_back('{p: p, wr: wr, d: wr ? wd : 4'h0, cyc: c0 + 1});
    dq.push_back('{m: m, err: exp_err, rdata: exp_rd,
                   cyc: (k >= 0) ? c0 + 2 + k : c0 + 1 + int'(TO)});
    drive(m, 1'b1, wr, p, wd);
    bus.data_in = (k >= 0) ? ~din : din;
    @(posedge clock); #1;
    if (k >= 0) begin
      repeat (k) begin @(posedge clock); #1; end
      bus.port_ready = 1'b1;
      bus.data_in    = din;
      @(posedge clock); #1;
      bus.port_ready = 1'b0;
      bus.data_in    = ~din;
    end
    wait_done(m, ok);
    chk("done_seen", int'(ok), 1);
    drive(m, 1'b0, 1'b0, 3'h0, 4'h0);
    bus.data_in = 4'h0;
  endtask

  // Both masters keep requesting writes; grants must alternate, 3 cycles apart.
  task automatic fair(input int n_each, input logic [3:0] r0, input logic [3:0] r1);
    int c0;
    int done0;
    int done1;
    done0 = 0;
    done1 = 0;
    @(posedge clock); #1;
    c0 = cyc;
    for (int j = 0; j < n_each; j++) begin
      sq.push_back('{p: 3'h1, wr: 1'b1, d: 4'h5, cyc: c0 + 1 + 6 * j});
      dq.push_back('{m: 0, err: 1'b0, rdata: r0, cyc: c0 + 2 + 6 * j});
      sq.push_back('{p: 3'h2, wr: 1'b1, d: 4'hC, cyc: c0 + 4 + 6 * j});
      dq.push_back('{m: 1, err: 1'b0, rdata: r1, cyc: c0 + 5 + 6 * j});
    end
    bus.port_ready = 1'b1;
    drive(0, 1'b1, 1'b1, 3'h1, 4'h5);
    drive(1, 1'b1, 1'b1, 3'h2, 4'hC);
    for (int i = 0; i < 6 * n_each; i++) begin
      @(negedge clock);
      if (bus.m0_done) begin done0++; bus.m0_req = 1'b0; end
      if (bus.m1_done) begin done1++; bus.m1_req = 1'b0; end
      @(posedge clock); #1;
      if (!bus.m0_req && done0 < n_each) bus.m0_req = 1'b1;
      if (!bus.m1_req && done1 < n_each) bus.m1_req = 1'b1;
    end
    chk("fair_done0", done0, n_each);
    chk("fair_done1", done1, n_each);
    bus.port_ready = 1'b0;
    drive(0, 1'b0, 1'b0, 3'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 3'h0, 4'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_port_id"}, int'(bus.port_id), 0);
    chk({tag, "_port_read"}, int'(bus.port_read), 0);
    chk({tag, "_port_write"}, int'(bus.port_write), 0);
    chk({tag, "_data_out"}, int'(bus.data_out), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_owner"}, int'(bus.owner), 0);
    chk({tag, "_m0_done"}, int'(bus.m0_done), 0);
    chk({tag, "_m1_done"}, int'(bus.m1_done), 0);
    chk({tag, "_m0_err"}, int'(bus.m0_err), 0);
    chk({tag, "_m1_err"}, int'(bus.m1_err), 0);
    chk({tag, "_m0_rdata"}, int'(bus.m0_rdata), 0);
    chk({tag, "_m1_rdata"}, int'(bus.m1_rdata), 0);
  endtask

  initial begin
    int c0;
    drive(0, 1'b0, 1'b0, 3'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 3'h0, 4'h0);
    bus.data_in    = 4'h0;
    bus.port_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    run_txn(0, 1'b1, 3'h3, 4'hA, 0, 4'h0, 1'b0, 4'h0);
    run_txn(1, 1'b0, 3'h5, 4'h0, 3, 4'h6, 1'b0, 4'h6);
    fair(2, 4'h0, 4'h6);
    run_txn(0, 1'b0, 3'h2, 4'h0, -1, 4'hF, 1'b1, 4'h0);
    run_txn(0, 1'b0, 3'h2, 4'h0, int'(TO) - 1, 4'h9, 1'b0, 4'h9);

    // Reset in the second WAIT cycle of an m0 write that never gets ready.
    @(posedge clock); #1;
    c0 = cyc;
    sq.push_back('{p: 3'h4, wr: 1'b1, d: 4'hF, cyc: c0 + 1});
    drive(0, 1'b1, 1'b1, 3'h4, 4'hF);
    repeat (3) begin @(posedge clock); #1; end
    chk("wait_busy_before_reset", int'(bus.busy), 1);
    chk("wait_port_id_before_reset", int'(bus.port_id), 4);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    drive(0, 1'b0, 1'b0, 3'h0, 4'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    fair(1, 4'h0, 4'h0);
    run_txn(1, 1'b0, 3'h7, 4'h0, 1, 4'h3, 1'b0, 4'h3);

    repeat (4) @(posedge clock);
    #1;
    chk("strobe_queue_drained", sq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/port_bus_arbiter.md
# port_bus_arbiter

Shares the central unit's 3-bit-address / 4-bit-data I/O port bus between two requesters: the command-controlled core (master 0) and a debug/loader path (master 1). Each port transaction is a one-cycle read or write strobe, followed by a wait for a peripheral `port_ready` acknowledgement, with a bounded timeout. Masters are served round-robin. The block sits between the requesters and the DataInput/DataOutput peripherals and is the only driver of the port bus.

## Interface
- `TIMEOUT`, default 8: maximum cycles a transaction waits for `port_ready`. Legal range is 1..255.
- `clock` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `m0_req`, `m1_req` in 1 each: transaction request. Must be held until the master's `done`.
- `m0_write`, `m1_write` in 1 each: 1 = write, 0 = read. Held with `req`.
- `m0_port`, `m1_port` in 3 each: target port id. Held with `req`.
- `m0_wdata`, `m1_wdata` in 4 each: write data. Held with `req`.
- `m0_rdata`, `m1_rdata` out 4 each: read result.
- `m0_done`, `m1_done` out 1 each: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1 each: timeout flag. Valid only while the matching `done` is high.
- `port_id` out 3: bus address.
- `port_read`, `port_write` out 1 each: one-cycle bus strobes.
- `data_out` out 4: bus write data.
- `data_in` in 4: bus read data.
- `port_ready` in 1: peripheral acknowledge.
- `busy` out 1: high in every state other than IDLE.
- `owner` out 1: index of the granted master. Meaningful while `busy` is high.

## Operation
- FSM states are IDLE, STROBE, WAIT and DONE. All outputs are registered.
- **IDLE:**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, that master wins.
  - If both are high, the master selected by the priority pointer `rr` wins.
  - On a win, latch the winner's `write`, `port` and `wdata`, set `owner`, toggle `rr` to the other master, and go to STROBE.
- **STROBE** (always exactly 1 cycle):
  - `port_read` or `port_write` is high, per the latched `write`.
  - `port_id` and `data_out` are driven. `data_out` is 0 on reads.
  - Next state is DONE if `port_ready` is high, otherwise WAIT.
- **WAIT:**
  - The strobe is low. `port_id` and `data_out` are held.
  - Go to DONE when `port_ready` is high.
- **Timeout:**
  - The cycle counter is cleared on entry to STROBE and counts STROBE and WAIT cycles with `port_ready` low.
  - When `TIMEOUT` such cycles have elapsed, go to DONE with error set.
  - If `port_ready` arrives in the final allowed cycle, it wins over the timeout: no error.
- **DONE** (always exactly 1 cycle):
  - The owner's `done` is high and its `err` equals the error flag.
  - On a successful read, the owner's `rdata` takes the `data_in` value captured at the `port_ready` edge.
  - On a timed-out read, the owner's `rdata` is 0.
  - On writes, the owner's `rdata` is unchanged.
  - Next state is IDLE.
- `rdata` holds its value until that master's next read completes.
- A request that drops before it is granted is ignored; no transaction is issued.
- A request still high in the IDLE cycle after `done` is treated as a new transaction. Masters drop `req` on seeing `done`.
- `port_ready` is ignored in IDLE and DONE.
- `port_id` and `data_out` are 0 in IDLE and DONE.

## Timing
- **Reset values:** all outputs 0; state IDLE; `rr` = 0 (master 0 favoured); counter and error flag cleared.
- **Reset mid-transaction:** strobes and bus outputs drop asynchronously. No `done` is issued; the in-flight request is abandoned.
- **Minimum latency:** request sampled in IDLE at cycle 0, strobe at cycle 1, `done` at cycle 2.
- **Latency with wait:** if `port_ready` first arrives at cycle 1+k (k ≥ 0, k < `TIMEOUT`), `done` is at cycle 2+k.
- **Timeout latency:** `done` with `err` at cycle 1+`TIMEOUT`.
- **Back-to-back throughput:** a new grant is possible in the IDLE cycle right after DONE, so at most one transaction every 3 cycles.
- The strobe is high for exactly one cycle per transaction, never in two consecutive cycles.

## Structure
- Package `cu_bus_pkg` holds:
  - `PORT_W` = 3 and `DATA_W` = 4;
  - the state enum `bus_state_t` (IDLE, STROBE, WAIT, DONE);
  - the bundled request typedef: write, port, wdata.
- Sub-module `rr_arbiter2` holds the two-input round-robin grant and the `rr` pointer. It is combinational grant logic plus a registered pointer that advances on accept.
- The counter width is the minimum that holds `TIMEOUT`.

## Test plan
- **Reset:** assert `reset` low mid-stream → every output is 0 and `busy` is 0. After release, IDLE with `rr` = 0.
- **Single write:** m0 writes port 3, data 0xA, with `port_ready` high in STROBE → `port_write` high one cycle with `port_id` = 3 and `data_out` = 0xA. `m0_done` is high at cycle 2 and `m0_err` = 0.
- **Read with wait:** m1 reads port 5; `port_ready` rises 3 cycles after the strobe with `data_in` = 0x6 → `m1_done` at cycle 5, `m1_rdata` = 6, `m1_err` = 0.
- **Fairness:** both masters request continuously from reset → grant order m0, m1, m0, m1. Each `done` is 3 cycles apart. No strobe overlap.
- **Timeout** (`TIMEOUT` = 4, `port_ready` never high, m0 read):
  - `m0_done` and `m0_err` are high at cycle 5, and `m0_rdata` = 0.
  - Repeat with `port_ready` high at cycle 4 → no error.
- **Reset in WAIT:** pull `reset` low in the second WAIT cycle → bus outputs are immediately 0 and no `done` is issued. A fresh m1 request after release completes normally.
